// File: rtl/command_dispatcher.sv
// Command dispatcher: pulls packets from a replayable upstream FIFO, offers each one
// to its destination target with a ready/valid hold, and replays the FIFO MAX_ITER times.
module command_dispatcher #(
    parameter int CMD_W    = 64,
    parameter int NUM_DST  = 4,
    parameter int MAX_ITER = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      fifo_rinc,
    input  logic [CMD_W-1:0]          fifo_rdata,
    output logic                      replay_iter_flag,
    output logic [NUM_DST-1:0]        dst_valid,
    input  logic [NUM_DST-1:0]        dst_ready,
    output logic [CMD_W-1:0]          dst_cmd,
    output logic [$clog2(MAX_ITER):0] iter_cnt,
    output logic                      busy,
    output logic                      done
);
    localparam int DST_W = $clog2(NUM_DST);
    localparam int IT_W  = $clog2(MAX_ITER) + 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_REPLAY = 3'd4;
    localparam logic [2:0] ST_FINISH = 3'd5;

    localparam logic [3:0]         OP_END_ITER = 4'hF;
    localparam logic [IT_W-1:0]    IT_MAX      = IT_W'(MAX_ITER);
    localparam logic [IT_W-1:0]    IT_ONE      = IT_W'(1);
    localparam logic [NUM_DST-1:0] DST_ONE     = NUM_DST'(1);

    logic [2:0]         state_r;
    logic [2:0]         state_s;
    logic [CMD_W-1:0]   hold_s;
    logic [IT_W-1:0]    iter_s;
    logic [NUM_DST-1:0] dst_valid_s;
    logic [DST_W-1:0]   hold_dest_s;
    logic               accept_s;

    // dst_cmd doubles as the hold register, so the accept decode reads its dest field
    assign hold_dest_s = dst_cmd[CMD_W-6 -: DST_W];
    assign accept_s    = dst_ready[hold_dest_s];

    // Next-state, hold-register and iteration-count decode
    always_comb begin
        state_s = state_r;
        hold_s  = dst_cmd;
        iter_s  = iter_cnt;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_FETCH;
                    iter_s  = {IT_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: state_s = ST_WAIT;
            ST_WAIT: begin
                // An all-zero word means the FIFO was empty: the valid bit is clear, so retry
                hold_s = fifo_rdata;
                if (!fifo_rdata[CMD_W-1]) begin
                    state_s = ST_FETCH;
                end else if (fifo_rdata[CMD_W-2 -: 4] == OP_END_ITER) begin
                    state_s = ST_REPLAY;
                    iter_s  = iter_cnt + IT_ONE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (accept_s) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_REPLAY: begin
                if (iter_cnt == IT_MAX) begin
                    state_s = ST_FINISH;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_FINISH: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // One-hot target offer for the command that will be held next cycle
    always_comb begin
        dst_valid_s = {NUM_DST{1'b0}};
        if (state_s == ST_HOLD) begin
            dst_valid_s = DST_ONE << hold_s[CMD_W-6 -: DST_W];
        end else begin
            dst_valid_s = {NUM_DST{1'b0}};
        end
    end

    // State and registered outputs, decoded from the next state so they align with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r          <= ST_IDLE;
            dst_cmd          <= {CMD_W{1'b0}};
            iter_cnt         <= {IT_W{1'b0}};
            dst_valid        <= {NUM_DST{1'b0}};
            fifo_rinc        <= 1'b0;
            replay_iter_flag <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            state_r          <= state_s;
            dst_cmd          <= hold_s;
            iter_cnt         <= iter_s;
            dst_valid        <= dst_valid_s;
            fifo_rinc        <= (state_s == ST_FETCH);
            replay_iter_flag <= (state_s == ST_REPLAY);
            busy             <= (state_s != ST_IDLE);
            done             <= (state_s == ST_FINISH);
        end
    end
endmodule

// File: tb/tb_command_dispatcher.sv
// Scoreboard bench for command_dispatcher: a replayable FIFO model feeds the DUT and
// a monitor pops expected dispatches (FIFO contents repeated MAX_ITER times) on every accept.
module tb_command_dispatcher;
    localparam int CMD_W    = 64;
    localparam int NUM_DST  = 4;
    localparam int MAX_ITER = 3;
    localparam int IT_W     = $clog2(MAX_ITER) + 1;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                start = 1'b0;
    logic                fifo_rinc;
    logic [CMD_W-1:0]    fifo_rdata = '0;
    logic                replay_iter_flag;
    logic [NUM_DST-1:0]  dst_valid;
    logic [NUM_DST-1:0]  dst_ready = '0;
    logic [CMD_W-1:0]    dst_cmd;
    logic [IT_W-1:0]     iter_cnt;
    logic                busy;
    logic                done;

    int checks = 0;
    int errors = 0;

    logic [CMD_W-1:0] mem [0:15];
    int               fifo_len = 0;
    int               rptr = 0;
    bit               fifo_clear = 1'b0;
    bit               rand_ready = 1'b0;
    logic [CMD_W-1:0] exp_q [$];
    int               accepts = 0;
    int               replay_seen = 0;
    int               done_seen = 0;

    command_dispatcher #(.CMD_W(CMD_W), .NUM_DST(NUM_DST), .MAX_ITER(MAX_ITER)) dut (
        .clk(clk), .reset(reset), .start(start), .fifo_rinc(fifo_rinc),
        .fifo_rdata(fifo_rdata), .replay_iter_flag(replay_iter_flag),
        .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_cmd(dst_cmd),
        .iter_cnt(iter_cnt), .busy(busy), .done(done)
    );

    initial forever #5 clk = ~clk;

    // Upstream FIFO model: read data the cycle after rinc, zero when empty, rewound on replay
    always @(posedge clk) begin
        if (fifo_clear || replay_iter_flag) rptr <= 0;
        else if (fifo_rinc && rptr < fifo_len) rptr <= rptr + 1;
        if (fifo_rinc) fifo_rdata <= (rptr < fifo_len) ? mem[rptr] : '0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [CMD_W-1:0] make_cmd(input logic [3:0] op, input logic [1:0] dest);
        logic [CMD_W-1:0] c;
        c = {$urandom, $urandom};
        c[63] = 1'b1;
        c[62:59] = op;
        c[58:57] = dest;
        return c;
    endfunction

    // Reference: the run dispatches every non-END command before END_ITER, MAX_ITER times over
    task automatic load_and_expect(input int n);
        fifo_len = n + 1;
        for (int it = 0; it < MAX_ITER; it++)
            for (int j = 0; j < n; j++) exp_q.push_back(mem[j]);
    endtask

    task automatic do_start();
        @(posedge clk); #2 start = 1'b1; fifo_clear = 1'b1;
        @(posedge clk); #2 start = 1'b0; fifo_clear = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (dst_valid != '0) seen = 1'b1;
        end
        chk(name, 64'(seen), 64'd1);
    endtask

    task automatic finish_run(input string name, input int r0, input int a0, input int d0, input int n_acc);
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk({name, "_done_timeout"}, 64'(seen), 64'd1);
        chk({name, "_iter_at_done"}, 64'(iter_cnt), 64'(MAX_ITER));
        chk({name, "_busy_at_done"}, 64'(busy), 64'd1);
        @(negedge clk);
        chk({name, "_busy_after"}, 64'(busy), 64'd0);
        chk({name, "_done_pulse"}, 64'(done), 64'd0);
        chk({name, "_iter_hold"}, 64'(iter_cnt), 64'(MAX_ITER));
        chk({name, "_replays"}, 64'(replay_seen - r0), 64'(MAX_ITER));
        chk({name, "_dones"}, 64'(done_seen - d0), 64'd1);
        chk({name, "_accepts"}, 64'(accepts - a0), 64'(n_acc));
        chk({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial forever begin
        @(posedge clk); #2;
        if (rand_ready) dst_ready = 4'($urandom_range(0, 15));
    end

    // Monitor: invariants every cycle, scoreboard pop on each handshake
    initial begin
        logic [NUM_DST-1:0] pv;
        logic [CMD_W-1:0]   pc;
        logic [CMD_W-1:0]   e;
        logic [NUM_DST-1:0] ev;
        bit                 pheld;
        pheld = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pheld = 1'b0;
            end else begin
                chk("rinc_replay_excl", 64'(fifo_rinc & replay_iter_flag), 64'd0);
                if (replay_iter_flag) replay_seen++;
                if (done) done_seen++;
                if (pheld) begin
                    chk("hold_valid_stable", 64'(dst_valid), 64'(pv));
                    chk("hold_cmd_stable", dst_cmd, pc);
                end
                if (dst_valid != '0) begin
                    chk("valid_onehot", 64'($onehot(dst_valid)), 64'd1);
                    if ((dst_valid & dst_ready) != '0) begin
                        pheld = 1'b0;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_dispatch", 64'(exp_q.size()), 64'd1);
                        end else begin
                            e = exp_q.pop_front();
                            ev = 4'b0001 << e[58:57];
                            chk("dispatch_cmd", dst_cmd, e);
                            chk("dispatch_dest", 64'(dst_valid), 64'(ev));
                            accepts++;
                        end
                    end else begin
                        pheld = 1'b1;
                        pv = dst_valid;
                        pc = dst_cmd;
                    end
                end else begin
                    pheld = 1'b0;
                end
            end
        end
    end

    initial begin
        int r0, a0, d0, n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rinc", 64'(fifo_rinc), 64'd0);
        chk("rst_replay", 64'(replay_iter_flag), 64'd0);
        chk("rst_valid", 64'(dst_valid), 64'd0);
        chk("rst_cmd", dst_cmd, 64'd0);
        chk("rst_iter", 64'(iter_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        @(posedge clk); #2 reset = 1'b1;

        // Basic dispatch and 3-cycle latency
        mem[0] = make_cmd(4'h1, 2'd2); mem[1] = make_cmd(4'hF, 2'd0);
        load_and_expect(1);
        dst_ready = 4'hF;
        r0 = replay_seen; a0 = accepts; d0 = done_seen;
        do_start();
        @(negedge clk); chk("lat_c1_busy", 64'(busy), 64'd1); chk("lat_c1_valid", 64'(dst_valid), 64'd0);
        @(negedge clk); chk("lat_c2_valid", 64'(dst_valid), 64'd0);
        @(negedge clk); chk("lat_c3_valid", 64'(dst_valid), 64'h4);
        finish_run("basic", r0, a0, d0, 3);

        // Backpressure on target 2 while target 1 is ready
        mem[0] = make_cmd(4'h1, 2'd2); mem[1] = make_cmd(4'h3, 2'd0); mem[2] = make_cmd(4'hF, 2'd1);
        load_and_expect(2);
        dst_ready = 4'h0;
        r0 = replay_seen; a0 = accepts; d0 = done_seen;
        do_start();
        wait_valid("bp_reach_hold");
        @(posedge clk); #2 dst_ready = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(dst_valid), 64'h4);
            chk("bp_cmd", dst_cmd, mem[0]);
        end
        chk("bp_no_accept", 64'(accepts - a0), 64'd0);
        @(posedge clk); #2 dst_ready = 4'hF;
        @(negedge clk); @(negedge clk);
        chk("bp_accept", 64'(accepts - a0), 64'd1);
        finish_run("bp", r0, a0, d0, 6);

        // Empty FIFO: FETCH/WAIT retry until a command is pushed
        fifo_len = 0;
        dst_ready = 4'hF;
        r0 = replay_seen; a0 = accepts; d0 = done_seen;
        do_start();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("empty_rinc", 64'(fifo_rinc), 64'((i % 2) == 0));
            chk("empty_valid", 64'(dst_valid), 64'd0);
        end
        @(posedge clk); #2;
        mem[0] = make_cmd(4'h5, 2'd3); mem[1] = make_cmd(4'hF, 2'd2);
        load_and_expect(1);
        finish_run("empty", r0, a0, d0, 3);

        // Reset while holding, then a clean restart
        mem[0] = make_cmd(4'h2, 2'd1); mem[1] = make_cmd(4'hF, 2'd0);
        load_and_expect(1);
        dst_ready = 4'h0;
        do_start();
        wait_valid("rst_reach_hold");
        @(posedge clk); #2 reset = 1'b0;
        #1;
        chk("midrst_valid", 64'(dst_valid), 64'd0);
        chk("midrst_cmd", dst_cmd, 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_iter", 64'(iter_cnt), 64'd0);
        chk("midrst_rinc", 64'(fifo_rinc | replay_iter_flag | done), 64'd0);
        exp_q.delete();
        @(posedge clk); #2 reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("postrst_idle", 64'(busy), 64'd0);
        dst_ready = 4'hF;
        load_and_expect(1);
        r0 = replay_seen; a0 = accepts; d0 = done_seen;
        do_start();
        @(negedge clk); chk("restart_iter", 64'(iter_cnt), 64'd0);
        finish_run("restart", r0, a0, d0, 3);

        // Randomized runs with random ready; odd runs also pulse start mid-run
        for (int run = 0; run < 6; run++) begin
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) mem[j] = make_cmd(4'($urandom_range(0, 14)), 2'($urandom_range(0, 3)));
            mem[n] = make_cmd(4'hF, 2'($urandom_range(0, 3)));
            load_and_expect(n);
            rand_ready = 1'b1;
            r0 = replay_seen; a0 = accepts; d0 = done_seen;
            do_start();
            if (run % 2 == 1) begin
                repeat (7) @(posedge clk);
                #2 start = 1'b1;
                @(posedge clk); #2 start = 1'b0;
                chk("busy_start_ignored", 64'(busy), 64'd1);
            end
            finish_run("rand", r0, a0, d0, MAX_ITER * n);
            rand_ready = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/command_dispatcher.md
COMMAND_DISPATCHER -- requirements
Module: command_dispatcher

Interface
REQ-001 Parameter CMD_W, default 64: command packet width in bits.
REQ-002 Parameter NUM_DST, default 4: number of execution targets; power of two, minimum 2.
REQ-003 Parameter MAX_ITER, default 16: replay iterations per run; minimum 1.
REQ-004 Packet fields: bit CMD_W-1 = valid; bits CMD_W-2..CMD_W-5 = opcode; next log2(NUM_DST) bits = dest; remaining bits = payload.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port start, input, 1: one-cycle pulse; begins a run; honoured only in IDLE.
REQ-008 Port fifo_rinc, output, 1: read-increment request to the upstream command FIFO.
REQ-009 Port fifo_rdata, input, CMD_W: FIFO read data; valid the cycle after fifo_rinc; all-zero when the FIFO was empty.
REQ-010 Port replay_iter_flag, output, 1: one-cycle pulse; rewinds the FIFO pointers for the next iteration.
REQ-011 Port dst_valid, output, NUM_DST: one-hot offer of the held command to a target.
REQ-012 Port dst_ready, input, NUM_DST: per-target accept.
REQ-013 Port dst_cmd, output, CMD_W: held command; shared by all targets.
REQ-014 Port iter_cnt, output, log2(MAX_ITER)+1: number of completed iterations.
REQ-015 Port busy, output, 1: high in every state except IDLE.
REQ-016 Port done, output, 1: one-cycle pulse when the run completes.

Function
REQ-017 States: IDLE, FETCH, WAIT, HOLD, REPLAY, FINISH.
REQ-018 IDLE: start=1 -> FETCH and iter_cnt cleared to 0; otherwise remain.
REQ-019 FETCH: fifo_rinc=1 for exactly one cycle -> WAIT.
REQ-020 WAIT: capture fifo_rdata into the hold register.
REQ-021 WAIT transitions: valid bit 0 (FIFO empty) -> FETCH (retry); valid=1 and opcode 4'hF (END_ITER) -> REPLAY; valid=1 and any other opcode -> HOLD.
REQ-022 HOLD: dst_valid[dest]=1, all other dst_valid bits 0; dst_cmd = hold register.
REQ-023 HOLD: the hold register and dst_valid stay stable until dst_ready[dest]=1; dst_ready on non-selected targets is ignored.
REQ-024 HOLD with dst_ready[dest]=1 -> FETCH on the next cycle; one accepted command per handshake cycle.
REQ-025 Command-to-target latency is 3 cycles: FETCH, WAIT, then HOLD presents the command.
REQ-026 REPLAY: replay_iter_flag=1 for exactly one cycle and iter_cnt increments.
REQ-027 REPLAY transitions: incremented iter_cnt == MAX_ITER -> FINISH; otherwise -> FETCH.
REQ-028 fifo_rinc and replay_iter_flag are never asserted in the same cycle.
REQ-029 FINISH: done=1 for one cycle -> IDLE; iter_cnt holds its final value until the next start.
REQ-030 start outside IDLE is ignored.
REQ-031 fifo_rdata is sampled only in WAIT.

Reset
REQ-032 reset=0 immediately forces: state IDLE, fifo_rinc=0, replay_iter_flag=0, dst_valid=0, dst_cmd=0, iter_cnt=0, busy=0, done=0.
REQ-033 Reset asserted mid-run drops any held command without a handshake; FIFO pointer recovery is the upstream block's responsibility.
REQ-034 After reset release, the block resumes only on a new start.

Verification
REQ-035 FIFO holds cmd(dest=2, opcode 1) then END_ITER; MAX_ITER=1; dst_ready all high; start -> dst_valid=4'b0100 exactly 3 cycles after start, replay_iter_flag pulse, done pulse, iter_cnt=1.
REQ-036 Backpressure: dst_ready[2]=0 for 5 cycles while holding -> dst_valid and dst_cmd stable for all 5 cycles; dst_ready[1]=1 during that window is ignored; accept on the cycle dst_ready[2] rises.
REQ-037 Empty FIFO after start -> repeating FETCH/WAIT, fifo_rinc pulsing every 2nd cycle, dst_valid=0; push a command -> it is dispatched.
REQ-038 MAX_ITER=3, FIFO holds 2 cmds + END_ITER -> 6 dispatches, 3 replay_iter_flag pulses, done once, iter_cnt=3.
REQ-039 Reset asserted while in HOLD -> all outputs 0 in the same cycle; a subsequent start restarts cleanly with iter_cnt=0.
REQ-040 start pulsed while busy -> no effect on state, iter_cnt, or outputs.
